dma_read_arbiter: RTL and testbench
===================================

# dma_read_arbiter

Round-robin arbiter and AHB-Lite read master that shares the single DMA read port between `N_REQ` requesters, such as the stream verifier and the FIFO reader. Each requester presents a word address. The block grants one requester at a time and issues one AHB-Lite SINGLE word read. It returns HRDATA, tagged one-hot to the winning requester. It sits between the verification/reader logic and the AHB-Lite interconnect.

## Interface
- `N_REQ`, default 2: number of requesters (2..8).
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width (fixed word reads).

- `CLK`  in  1: clock, rising edge.
- `RESETn`  in  1: reset. One clock; reset is asynchronous and active-low.
- `i_req`  in  N_REQ: per-requester read request. Level; held until the matching `o_ack` bit is seen.
- `i_addr`  in  N_REQ*ADDR_W: requester k address is `i_addr[k*ADDR_W +: ADDR_W]`.
- `o_ack`  out  N_REQ: one-hot, 1-cycle pulse. The address phase for that requester was accepted.
- `o_rdata`  out  DATA_W: read data. Holds its value until the next completion.
- `o_rdata_valid`  out  N_REQ: one-hot, 1-cycle pulse. `o_rdata` belongs to that requester.
- `o_err`  out  1: 1-cycle pulse, coincident with `o_rdata_valid`, when the slave returned ERROR.
- `o_busy`  out  1: high whenever the state is not IDLE.
- `HADDR`  out  ADDR_W: AHB address. Bits [1:0] are always 0.
- `HTRANS`  out  2: IDLE (00) or NONSEQ (10) only.
- `HWRITE`  out  1: constant 0.
- `HSIZE`  out  3: constant 3'b010 (word).
- `HBURST`  out  3: constant 3'b000 (SINGLE).
- `HREADY`  in  1: transfer ready.
- `HRESP`  in  1: 0 = OKAY, 1 = ERROR.
- `HRDATA`  in  DATA_W: read data.

## Operation
- State machine: IDLE, ADDR, DATA. Only one transfer is outstanding at a time; there is no address/data pipelining.
- IDLE:
  - `i_req` is sampled only in this state.
  - If any bit is set, pick a winner by round-robin. Search starts at `(last+1) mod N_REQ`.
  - Register the winner index in `gnt`. Latch `HADDR <= {addr[ADDR_W-1:2],2'b00}` and `HTRANS <= NONSEQ`. Go to ADDR.
- ADDR:
  - While HREADY=0, hold HADDR and HTRANS. This covers a previous slave still stretching the bus.
  - When HREADY=1: `HTRANS <= IDLE`, `o_ack[gnt] <= 1`, go to DATA.
- DATA:
  - While HREADY=0, wait.
  - When HREADY=1: `o_rdata <= HRDATA`, `o_rdata_valid[gnt] <= 1`, `o_err <= HRESP`, `last <= gnt`, go to IDLE.
  - A two-cycle ERROR response (HRESP=1, HREADY=0, then HRESP=1, HREADY=1) completes on its second cycle only.
- Misaligned address: low 2 bits are cleared. The aligned word is returned. No error is flagged.
- `i_req` dropped before grant: not granted. `i_req` or `i_addr` changed after grant: no effect; the transfer completes and data is returned.
- `last` reset value is N_REQ-1, so requester 0 has first priority out of reset.
- Async reset, including mid-transfer:
  - State returns to IDLE immediately; any outstanding transfer is abandoned with no `o_ack` or `o_rdata_valid`.
  - Output reset values: `HADDR=0`, `HTRANS=00`, `o_ack=0`, `o_rdata_valid=0`, `o_err=0`, `o_rdata=0`, `o_busy=0`.
  - Constant outputs `HWRITE`, `HSIZE` and `HBURST` are unaffected.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Zero-wait-state read, with the request seen at edge 0:
  - Cycle 1: HTRANS=NONSEQ, HADDR valid.
  - Cycle 2: HTRANS=IDLE, `o_ack` pulse.
  - Cycle 3: `o_rdata_valid` pulse, state IDLE.
- Each HREADY=0 cycle in the ADDR or DATA phase adds one cycle.
- Requester rule: drop `i_req` on the edge where `o_ack` is seen. It is then 0 when IDLE next samples.
- Back-to-back: a new grant can occur at the edge ending the `o_rdata_valid` cycle. Peak throughput is 1 read per 3 cycles.
- Round-robin pointer updates only on completion. A reset-aborted transfer does not advance it.

## Test plan
- Single read, requester 0, addr 0x2000_0010, slave returns 0xDEADBEEF with no waits:
  - NONSEQ/HADDR 0x2000_0010 in cycle 1.
  - `o_ack=01` in cycle 2.
  - `o_rdata=0xDEADBEEF`, `o_rdata_valid=01`, `o_err=0` in cycle 3.
- Both requesters held continuously, re-raising after each ack, addrs 0x100 and 0x200:
  - Grants alternate 0,1,0,1.
  - HADDR sequence is 0x100, 0x200, 0x100, 0x200.
- Wait states: HREADY low for 2 cycles in ADDR and 3 cycles in DATA:
  - `o_ack` appears 2 cycles late.
  - `o_rdata_valid` appears 5 cycles late; HADDR and HTRANS are stable throughout.
- ERROR response on requester 1:
  - HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1.
  - Response: `o_rdata_valid=10` and `o_err=1` in the same cycle, once.
- Reset asserted during DATA:
  - HTRANS=00, `o_busy=0` and all pulses 0 immediately.
  - After release, requester 0 wins first.
- Misaligned addr 0x0000_0107 from requester 0: HADDR=0x0000_0104 and `o_err=0`.

Source files
------------

// File: rtl/dma_read_arbiter_if.sv
// Requester-side and AHB-Lite read-port signals of the DMA read arbiter.
// master = the arbiter; slave = requesters plus the AHB slave/interconnect side.
interface dma_read_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        i_req;
  logic [N_REQ*ADDR_W-1:0] i_addr;
  logic [N_REQ-1:0]        o_ack;
  logic [DATA_W-1:0]       o_rdata;
  logic [N_REQ-1:0]        o_rdata_valid;
  logic                    o_err;
  logic                    o_busy;
  logic [ADDR_W-1:0]       HADDR;
  logic [1:0]              HTRANS;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [2:0]              HBURST;
  logic                    HREADY;
  logic                    HRESP;
  logic [DATA_W-1:0]       HRDATA;

  modport master (
    input  i_req, i_addr, HREADY, HRESP, HRDATA,
    output o_ack, o_rdata, o_rdata_valid, o_err, o_busy,
           HADDR, HTRANS, HWRITE, HSIZE, HBURST
  );

  modport slave (
    output i_req, i_addr, HREADY, HRESP, HRDATA,
    input  o_ack, o_rdata, o_rdata_valid, o_err, o_busy,
           HADDR, HTRANS, HWRITE, HSIZE, HBURST
  );
endinterface

// File: rtl/dma_read_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite read port among N_REQ requesters;
// one non-pipelined SINGLE word read at a time, data returned tagged one-hot.
module dma_read_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                CLK,
  input logic                RESETn,
  dma_read_arbiter_if.master bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  logic [1:0]        state;
  logic [IDX_W-1:0]  gnt;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  win;
  logic              win_vld;
  logic [ADDR_W-1:0] win_addr;

  // Walk downward so the candidate nearest (last+1) is the final assignment.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx     = '0;
    win     = last;
    win_vld = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IDX_W'((int'(last) + i) % N_REQ);
      if (bus.i_req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign win_addr = bus.i_addr[int'(win)*ADDR_W +: ADDR_W];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state             <= S_IDLE;
      gnt               <= '0;
      last              <= IDX_W'(N_REQ-1);
      bus.HADDR         <= '0;
      bus.HTRANS        <= HT_IDLE;
      bus.o_ack         <= '0;
      bus.o_rdata_valid <= '0;
      bus.o_err         <= 1'b0;
      bus.o_rdata       <= '0;
    end else begin
      bus.o_ack         <= '0;
      bus.o_rdata_valid <= '0;
      bus.o_err         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            gnt        <= win;
            bus.HADDR  <= win_addr & ~ADDR_W'(3);
            bus.HTRANS <= HT_NONSEQ;
            state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          // HREADY low here means an earlier slave is still stretching the bus.
          if (bus.HREADY) begin
            bus.HTRANS <= HT_IDLE;
            bus.o_ack  <= N_REQ'(1) << gnt;
            state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (bus.HREADY) begin
            bus.o_rdata       <= bus.HRDATA;
            bus.o_rdata_valid <= N_REQ'(1) << gnt;
            bus.o_err         <= bus.HRESP;
            last              <= gnt;
            state             <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy = (state != S_IDLE);
  assign bus.HWRITE = 1'b0;
  assign bus.HSIZE  = 3'b010;
  assign bus.HBURST = 3'b000;

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Directed bench for dma_read_arbiter: N_REQ=2, bench acts as requesters and AHB slave.
module tb_dma_read_arbiter;
  logic CLK;
  logic RESETn;
  int   n_vec = 0;
  int   n_err = 0;

  dma_read_arbiter_if #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

  dma_read_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses and bus-state snapshot in one call.
  task automatic chk_bus(input string tag, input logic [1:0] htrans, input logic [31:0] haddr,
                         input logic [1:0] ack, input logic [1:0] vld, input logic busy);
    chk({tag, ".HTRANS"}, 64'(bus.HTRANS), 64'(htrans));
    chk({tag, ".HADDR"},  64'(bus.HADDR),  64'(haddr));
    chk({tag, ".o_ack"},  64'(bus.o_ack),  64'(ack));
    chk({tag, ".o_rdata_valid"}, 64'(bus.o_rdata_valid), 64'(vld));
    chk({tag, ".o_busy"}, 64'(bus.o_busy), 64'(busy));
  endtask

  initial begin
    logic [31:0] exp_a;
    RESETn     = 1'b0;
    bus.i_req  = 2'b00;
    bus.i_addr = '0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = '0;
    #12;

    // Reset state and constant outputs
    chk_bus("rst", 2'b00, 32'h0, 2'b00, 2'b00, 1'b0);
    chk("rst.o_err",   64'(bus.o_err),   64'h0);
    chk("rst.o_rdata", 64'(bus.o_rdata), 64'h0);
    chk("HWRITE", 64'(bus.HWRITE), 64'h0);
    chk("HSIZE",  64'(bus.HSIZE),  64'h2);
    chk("HBURST", 64'(bus.HBURST), 64'h0);
    tick();
    RESETn = 1'b1;

    // Single zero-wait read, requester 0
    bus.i_req  = 2'b01;
    bus.i_addr = {32'h0, 32'h2000_0010};
    tick();
    chk_bus("t1.c1", 2'b10, 32'h2000_0010, 2'b00, 2'b00, 1'b1);
    bus.HRDATA = 32'hDEAD_BEEF;
    tick();
    chk_bus("t1.c2", 2'b00, 32'h2000_0010, 2'b01, 2'b00, 1'b1);
    bus.i_req = 2'b00;
    tick();
    chk_bus("t1.c3", 2'b00, 32'h2000_0010, 2'b00, 2'b01, 1'b0);
    chk("t1.rdata", 64'(bus.o_rdata), 64'hDEAD_BEEF);
    chk("t1.err",   64'(bus.o_err),   64'h0);
    tick();
    chk("t1.hold.rdata", 64'(bus.o_rdata), 64'hDEAD_BEEF);
    chk("t1.hold.vld",   64'(bus.o_rdata_valid), 64'h0);

    // Reset so requester 0 has priority again, then two contending requesters
    RESETn = 1'b0;
    tick();
    RESETn = 1'b1;
    bus.i_addr = {32'h0000_0200, 32'h0000_0100};
    bus.i_req  = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_a = (g % 2 == 0) ? 32'h100 : 32'h200;
      tick();
      chk_bus($sformatf("rr%0d.c1", g), 2'b10, exp_a, 2'b00, 2'b00, 1'b1);
      bus.HRDATA = 32'h1000 + 32'(g);
      tick();
      chk_bus($sformatf("rr%0d.c2", g), 2'b00, exp_a, 2'b01 << (g % 2), 2'b00, 1'b1);
      bus.i_req[g % 2] = 1'b0;
      tick();
      chk_bus($sformatf("rr%0d.c3", g), 2'b00, exp_a, 2'b00, 2'b01 << (g % 2), 1'b0);
      chk($sformatf("rr%0d.rdata", g), 64'(bus.o_rdata), 64'h1000 + 64'(g));
      bus.i_req[g % 2] = 1'b1;
    end
    bus.i_req = 2'b00;

    // Wait states: 2 in ADDR, 3 in DATA (last=1, so requester 0 wins)
    bus.i_addr = {32'h0, 32'h0000_0300};
    bus.i_req  = 2'b01;
    bus.HREADY = 1'b0;
    tick();
    chk_bus("ws.c1", 2'b10, 32'h300, 2'b00, 2'b00, 1'b1);
    tick();
    chk_bus("ws.a1", 2'b10, 32'h300, 2'b00, 2'b00, 1'b1);
    tick();
    chk_bus("ws.a2", 2'b10, 32'h300, 2'b00, 2'b00, 1'b1);
    bus.HREADY = 1'b1;
    tick();
    chk_bus("ws.ack", 2'b00, 32'h300, 2'b01, 2'b00, 1'b1);
    bus.i_req  = 2'b00;
    bus.HREADY = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      chk_bus($sformatf("ws.d%0d", w), 2'b00, 32'h300, 2'b00, 2'b00, 1'b1);
    end
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'hCAFE_0003;
    tick();
    chk_bus("ws.vld", 2'b00, 32'h300, 2'b00, 2'b01, 1'b0);
    chk("ws.rdata", 64'(bus.o_rdata), 64'hCAFE_0003);

    // Two-cycle ERROR response on requester 1
    bus.i_addr = {32'h0000_0404, 32'h0};
    bus.i_req  = 2'b10;
    tick();
    chk_bus("er.c1", 2'b10, 32'h404, 2'b00, 2'b00, 1'b1);
    tick();
    chk_bus("er.ack", 2'b00, 32'h404, 2'b10, 2'b00, 1'b1);
    bus.i_req  = 2'b00;
    bus.HRESP  = 1'b1;
    bus.HREADY = 1'b0;
    bus.HRDATA = 32'h0000_0BAD;
    tick();
    chk("er.first.vld", 64'(bus.o_rdata_valid), 64'h0);
    chk("er.first.err", 64'(bus.o_err), 64'h0);
    bus.HREADY = 1'b1;
    tick();
    chk("er.vld", 64'(bus.o_rdata_valid), 64'h2);
    chk("er.err", 64'(bus.o_err), 64'h1);
    bus.HRESP = 1'b0;
    tick();
    chk("er.once.vld", 64'(bus.o_rdata_valid), 64'h0);
    chk("er.once.err", 64'(bus.o_err), 64'h0);

    // Misaligned address from requester 0
    bus.i_addr = {32'h0, 32'h0000_0107};
    bus.i_req  = 2'b01;
    tick();
    chk_bus("mis.c1", 2'b10, 32'h0000_0104, 2'b00, 2'b00, 1'b1);
    tick();
    bus.i_req  = 2'b00;
    bus.HRDATA = 32'h0000_0055;
    tick();
    chk_bus("mis.c3", 2'b00, 32'h0000_0104, 2'b00, 2'b01, 1'b0);
    chk("mis.err",   64'(bus.o_err),   64'h0);
    chk("mis.rdata", 64'(bus.o_rdata), 64'h55);

    // Reset during DATA; last is 0 here, so only a reset pointer lets 0 win next
    bus.i_addr = {32'h0000_0500, 32'h0};
    bus.i_req  = 2'b10;
    tick();
    tick();
    chk("ar.ack", 64'(bus.o_ack), 64'h2);
    bus.i_req  = 2'b00;
    bus.HREADY = 1'b0;
    tick();
    RESETn = 1'b0;
    #1;
    chk_bus("ar.rst", 2'b00, 32'h0, 2'b00, 2'b00, 1'b0);
    chk("ar.err",   64'(bus.o_err),   64'h0);
    chk("ar.rdata", 64'(bus.o_rdata), 64'h0);
    bus.HREADY = 1'b1;
    tick();
    chk("ar.hold.vld", 64'(bus.o_rdata_valid), 64'h0);
    RESETn     = 1'b1;
    bus.i_addr = {32'h0000_0700, 32'h0000_0600};
    bus.i_req  = 2'b11;
    tick();
    chk_bus("ar.win", 2'b10, 32'h600, 2'b00, 2'b00, 1'b1);
    bus.HRDATA = 32'h0000_6000;
    tick();
    chk("ar.win.ack", 64'(bus.o_ack), 64'h1);
    bus.i_req = 2'b10;
    tick();
    chk("ar.win.vld", 64'(bus.o_rdata_valid), 64'h1);
    chk("ar.win.rdata", 64'(bus.o_rdata), 64'h6000);
    bus.i_req = 2'b00;
    tick();
    chk("idle.busy", 64'(bus.o_busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
